// File: rtl/aes_key_schedule_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_ks_pkg
// Shared constants and types for the AES key-schedule controller slice.
//   KEY_W       : key / round-key width in bits
//   NUM_ROUNDS  : number of expansion rounds (bank depth is NUM_ROUNDS+1)
//   round_idx_t : 4-bit round index, used for RCON select and bank addressing
//   ks_state_e  : controller FSM states
// ---------------------------------------------------------------------------
package aes_ks_pkg;

  localparam int KEY_W      = 128;
  localparam int NUM_ROUNDS = 10;
  localparam int RIDX_W     = 4;

  typedef logic [RIDX_W-1:0] round_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ks_state_e;

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_ctrl_if
// Key-load handshake, status flags and round-key read port between the
// key source / cipher datapath (master) and the key-schedule controller
// (slave).
//   key_valid    master->slave  cipher key offered
//   key_ready    slave->master  controller can accept a key
//   key_in       master->slave  cipher key
//   busy         slave->master  expansion in progress
//   done         slave->master  one-cycle pulse, bank complete
//   rk_all_valid slave->master  bank holds a complete schedule
//   rk_rd_idx    master->slave  round-key read index
//   rk_rd_data   slave->master  round key at rk_rd_idx (combinational)
// ---------------------------------------------------------------------------
interface aes_key_schedule_ctrl_if
  import aes_ks_pkg::*;
#(
  parameter int KEY_W = aes_ks_pkg::KEY_W
);

  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_in;
  logic             busy;
  logic             done;
  logic             rk_all_valid;
  round_idx_t       rk_rd_idx;
  logic [KEY_W-1:0] rk_rd_data;

  modport master (
    output key_valid, key_in, rk_rd_idx,
    input  key_ready, busy, done, rk_all_valid, rk_rd_data
  );

  modport slave (
    input  key_valid, key_in, rk_rd_idx,
    output key_ready, busy, done, rk_all_valid, rk_rd_data
  );

endinterface

// File: rtl/aes_key_schedule_ctrl_bank.sv
// ---------------------------------------------------------------------------
// aes_round_key_bank
// Register bank holding all round keys of one schedule.
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-high reset, zeroes every entry
//   clr_i      in  synchronous clear of every entry
//   wr_en_i    in  write strobe
//   wr_idx_i   in  write index
//   wr_data_i  in  write data
//   rd_idx_i   in  read index
//   rd_data_o  out entry at rd_idx_i, zero when rd_idx_i >= DEPTH
// ---------------------------------------------------------------------------
module aes_round_key_bank
  import aes_ks_pkg::*;
#(
  parameter int KEY_W = aes_ks_pkg::KEY_W,
  parameter int DEPTH = aes_ks_pkg::NUM_ROUNDS + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  round_idx_t       wr_idx_i,
  input  logic [KEY_W-1:0] wr_data_i,
  input  round_idx_t       rd_idx_i,
  output logic [KEY_W-1:0] rd_data_o
);

  logic [KEY_W-1:0] bank_q [DEPTH];

  // Every entry is reset/cleared as a whole, so the bank lives in flops
  // rather than a RAM macro.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bank_q[gi] <= '0;
      end else if (clr_i) begin
        bank_q[gi] <= '0;
      end else if (wr_en_i && (wr_idx_i == round_idx_t'(gi))) begin
        bank_q[gi] <= wr_data_i;
      end
    end
  end

  // Decoded mux; any index with no matching entry falls through to zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx_i == round_idx_t'(i)) begin
        rd_data_o = bank_q[i];
      end
    end
  end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_ctrl
// Drives an external single-round key generator through NUM_ROUNDS
// expansions, feeding each round's output back as the next input, and
// stores every round key in an internal bank readable by index.
//   clk          in  system clock, rising edge
//   rst          in  asynchronous active-high reset
//   ks_if        slave modport: key handshake, status, round-key read port
//   gen_in_key   out generator input key (registered)
//   gen_round    out generator round index / RCON select (registered)
//   gen_out_key  in  generator output, valid GEN_LATENCY edges after input
//   zeroize      in  synchronous clear of the schedule (only when the macro
//                    AES_KEY_SCHED_ZEROIZE_EN is defined)
// ---------------------------------------------------------------------------
module aes_key_schedule_ctrl
  import aes_ks_pkg::*;
#(
  parameter int KEY_W       = aes_ks_pkg::KEY_W,
  parameter int NUM_ROUNDS  = aes_ks_pkg::NUM_ROUNDS,
  parameter int GEN_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  aes_key_schedule_ctrl_if.slave    ks_if,
  output logic [KEY_W-1:0]          gen_in_key,
  output round_idx_t                gen_round,
  input  logic [KEY_W-1:0]          gen_out_key
`ifdef AES_KEY_SCHED_ZEROIZE_EN
  ,
  input  logic                      zeroize
`endif
);

  localparam int CNT_W = (GEN_LATENCY < 2) ? 1 : $clog2(GEN_LATENCY + 1);

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] gen_in_key_q, gen_in_key_d;
  round_idx_t       gen_round_q, gen_round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rk_all_valid_q, rk_all_valid_d;

  logic             key_ready, busy, done;
  logic             bank_we;
  round_idx_t       bank_widx;
  logic [KEY_W-1:0] bank_wdata;
  logic             clr;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign clr = zeroize;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      gen_in_key_q   <= '0;
      gen_round_q    <= '0;
      cnt_q          <= '0;
      rk_all_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gen_in_key_q   <= gen_in_key_d;
      gen_round_q    <= gen_round_d;
      cnt_q          <= cnt_d;
      rk_all_valid_q <= rk_all_valid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gen_in_key_d   = gen_in_key_q;
    gen_round_d    = gen_round_q;
    cnt_d          = cnt_q;
    rk_all_valid_d = rk_all_valid_q;
    bank_we        = 1'b0;
    bank_widx      = round_idx_t'(gen_round_q + round_idx_t'(1));
    bank_wdata     = gen_out_key;
    key_ready      = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;

    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (ks_if.key_valid) begin
          bank_we        = 1'b1;
          bank_widx      = '0;
          bank_wdata     = ks_if.key_in;
          gen_in_key_d   = ks_if.key_in;
          gen_round_d    = '0;
          // Counter starts at 1: the accept edge itself is the first of
          // the GEN_LATENCY edges the generator needs.
          cnt_d          = CNT_W'(1);
          rk_all_valid_d = 1'b0;
          state_d        = RUN;
        end
      end

      RUN: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(GEN_LATENCY)) begin
          // Capture round gen_round's result into slot gen_round+1 and
          // feed it straight back as the next round's input.
          bank_we      = 1'b1;
          gen_in_key_d = gen_out_key;
          cnt_d        = CNT_W'(1);
          if (gen_round_q == round_idx_t'(NUM_ROUNDS - 1)) begin
            gen_round_d    = '0;
            rk_all_valid_d = 1'b1;
            state_d        = DONE;
          end else begin
            gen_round_d = round_idx_t'(gen_round_q + round_idx_t'(1));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Clear wins over everything, including an accept in the same cycle.
    if (clr) begin
      state_d        = IDLE;
      gen_in_key_d   = '0;
      gen_round_d    = '0;
      cnt_d          = '0;
      rk_all_valid_d = 1'b0;
      bank_we        = 1'b0;
    end
  end

  aes_round_key_bank #(
    .KEY_W (KEY_W),
    .DEPTH (NUM_ROUNDS + 1)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr),
    .wr_en_i   (bank_we),
    .wr_idx_i  (bank_widx),
    .wr_data_i (bank_wdata),
    .rd_idx_i  (ks_if.rk_rd_idx),
    .rd_data_o (ks_if.rk_rd_data)
  );

  assign gen_in_key         = gen_in_key_q;
  assign gen_round          = gen_round_q;
  assign ks_if.key_ready    = key_ready;
  assign ks_if.busy         = busy;
  assign ks_if.done         = done;
  assign ks_if.rk_all_valid = rk_all_valid_q;

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
- Sequences the single-round key generator through all NUM_ROUNDS expansions.
- Each round's output is fed back as the next round's input key, with the round number applied as the RCON index.
- All NUM_ROUNDS+1 round keys are held in an internal bank, and the cipher datapath reads them by index.
- Sits between the key-load interface and the round datapath. The generator stays a separate instance, driven through the gen_* ports.

Parameters:
- KEY_W, 128: key and round-key width in bits.
- NUM_ROUNDS, 10: number of expansion rounds. Bank depth is NUM_ROUNDS+1.
- GEN_LATENCY, 2: clock edges from a stable gen_in_key/gen_round until gen_out_key is valid. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  controller can accept a key.
- key_in  in  KEY_W  cipher key.
- gen_in_key  out  KEY_W  generator input key (registered).
- gen_round  out  4  generator round index / RCON select (registered).
- gen_out_key  in  KEY_W  generator output.
- busy  out  1  expansion in progress.
- done  out  1  single-cycle pulse when the bank is complete.
- rk_all_valid  out  1  bank holds a complete, consistent schedule.
- rk_rd_idx  in  4  round-key read index.
- rk_rd_data  out  KEY_W  round key at rk_rd_idx (combinational read).

Behaviour:
- Reset (async assert, takes effect immediately):
  - state=IDLE.
  - key_ready=1; busy, done, rk_all_valid = 0.
  - gen_in_key=0, gen_round=0, wait counter=0.
  - All bank entries = 0.
- States:
  - IDLE: key_ready=1.
  - RUN: key_ready=0, busy=1.
  - DONE: exactly one cycle; done=1, key_ready=0. Then returns to IDLE.
- Accept:
  - Occurs at an edge where state=IDLE and key_valid=1 (key_ready is implied).
  - At that edge: bank[0]←key_in; gen_in_key←key_in; gen_round←0; wait counter←1; rk_all_valid←0; state←RUN.
- RUN, capture rule:
  - Counter increments each edge.
  - At the edge where counter==GEN_LATENCY, gen_out_key is sampled into bank[gen_round+1].
  - At the same edge: gen_in_key←gen_out_key; gen_round←gen_round+1; counter←1.
- RUN, completion:
  - When gen_round==NUM_ROUNDS-1 at a capture edge, the capture writes bank[NUM_ROUNDS].
  - At that edge: gen_round←0; rk_all_valid←1; state←DONE.
- Latency:
  - The last capture occurs NUM_ROUNDS×GEN_LATENCY edges after the accept edge.
  - done is high in the following cycle, i.e. 20 cycles after the accept cycle with defaults.
- key_valid outside IDLE is ignored. There is no queueing, and the key must be held by the source until accepted.
- Read port:
  - rk_rd_data = bank[rk_rd_idx].
  - Returns 0 when rk_rd_idx > NUM_ROUNDS.
  - Reads are legal at any time. During RUN, entries not yet rewritten hold the previous schedule, and rk_all_valid=0 flags this.
- Reset mid-RUN: everything returns to reset values immediately. Partial keys are discarded and the bank is zeroed.
- Back-to-back loads: DONE→IDLE costs one cycle, so the next accept is possible at the earliest 2 cycles after the last capture.

Optional Feature:
- Macro: AES_KEY_SCHED_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - zeroize=1 at any edge, in any state, performs a synchronous clear: bank entries, gen_in_key, gen_round, counter and rk_all_valid go to 0, and state←IDLE. done is not pulsed.
  - zeroize takes priority over accept in the same cycle.
- Undefined: no zeroize port exists, and the bank is cleared only by rst.

Decomposition:
- Package aes_ks_pkg holds:
  - KEY_W and NUM_ROUNDS constants.
  - The state enum {IDLE, RUN, DONE}.
  - The round-index typedef (4-bit).
- Natural sub-module: aes_round_key_bank.
  - NUM_ROUNDS+1 × KEY_W registers, one write port, one combinational read port with out-of-range→0, clear input.
  - The controller FSM and counter stay in the top module.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst mid-simulation.
  - Required: key_ready=1, busy=0, done=0, rk_all_valid=0, and rk_rd_data=0 for every idx 0..15.
- FIPS-197 vector (real generator instance, standard S-box):
  - Stimulus: key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: bank[1]=a0fafe1788542cb123a339392a6c7605, bank[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; done pulses exactly 20 cycles after the accept cycle, for 1 cycle.
- Timing with stub generator (GEN_LATENCY=3; stub output = in_key ^ {124'h0, round+1}):
  - Stimulus: key 0.
  - Required: captures every 3 edges, gen_round steps 0..9, bank[10]=0x...0b, done 30 cycles after accept.
- Busy lockout:
  - Stimulus: hold key_valid=1 with a different key during RUN.
  - Required: key_ready=0 and bank[0] unchanged; the new key is accepted on the cycle after DONE.
- Reset mid-run:
  - Stimulus: assert rst after round 4 capture.
  - Required: immediate IDLE and all bank entries 0; a new load completes normally with correct keys.
- Zeroize (AES_KEY_SCHED_ZEROIZE_EN):
  - Stimulus 1: pulse zeroize in RUN with key_valid=1. Required: IDLE next cycle, bank zeroed, no done, key not accepted that cycle.
  - Stimulus 2: pulse zeroize after completion. Required: rk_all_valid drops to 0.
